// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single common data bus (CDB) between the ALU and the LSB.
//   Each producer feeds a small FIFO. A round-robin arbiter moves one FIFO head
//   per cycle onto a registered broadcast bus, which the ROB, RS and LSB consume.
//   Producers see valid/ready backpressure. rst and flush clear all state.
//
// Configuration macro:
//   CDB_BYPASS_EN - a source with an empty FIFO and a valid input competes with
//                   its live input. If that input wins, it goes straight onto the
//                   bus without a FIFO write, so an idle bus has 1-cycle latency.
//                   When the macro is undefined, every entry passes through a
//                   FIFO and latency is 2 cycles.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   rdy_i                 global enable; while low, all state holds
//   flush_i               ROB wrong-commit; same effect as rst
//   alu_*_i / alu_ready_o ALU result offer (res, rob_id, jump_choice, pc)
//   lsb_*_i / lsb_ready_o LSB result offer (res, rob_id)
//   cdb_*_o               registered broadcast (valid, src 0=ALU/1=LSB, res,
//                         rob_id, jump_choice, pc; jump_choice/pc are 0 for LSB)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy_i,
  input  logic                flush_i,
  input  logic                alu_valid_i,
  input  logic [DATA_W-1:0]   alu_res_i,
  input  logic [ROB_ID_W-1:0] alu_rob_id_i,
  input  logic                alu_jump_choice_i,
  input  logic [DATA_W-1:0]   alu_pc_i,
  output logic                alu_ready_o,
  input  logic                lsb_valid_i,
  input  logic [DATA_W-1:0]   lsb_res_i,
  input  logic [ROB_ID_W-1:0] lsb_rob_id_i,
  output logic                lsb_ready_o,
  output logic                cdb_valid_o,
  output logic                cdb_src_o,
  output logic [DATA_W-1:0]   cdb_res_o,
  output logic [ROB_ID_W-1:0] cdb_rob_id_o,
  output logic                cdb_jump_choice_o,
  output logic [DATA_W-1:0]   cdb_pc_o
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]   res;
    logic [ROB_ID_W-1:0] rob_id;
    logic                jump_choice;
    logic [DATA_W-1:0]   pc;
  } entry_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  entry_t alu_mem_q [FIFO_DEPTH];
  entry_t lsb_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_wptr_q, alu_rptr_q, lsb_wptr_q, lsb_rptr_q;
  logic [PTR_W:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e             last_grant_q, last_grant_d;
  src_e             cdb_src_q, cdb_src_d;
  logic             cdb_valid_q, cdb_valid_d;
  entry_t           cdb_q, cdb_d;

  entry_t alu_in, lsb_in, alu_head, lsb_head;
  logic   alu_live, lsb_live, alu_cand, lsb_cand;
  logic   grant_alu, grant_lsb;
  logic   alu_push, lsb_push, alu_pop, lsb_pop;

  // NOTE: every signal written here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    alu_in             = '0;
    alu_in.res         = alu_res_i;
    alu_in.rob_id      = alu_rob_id_i;
    alu_in.jump_choice = alu_jump_choice_i;
    alu_in.pc          = alu_pc_i;
    // LSB entries carry no branch information on the bus.
    lsb_in             = '0;
    lsb_in.res         = lsb_res_i;
    lsb_in.rob_id      = lsb_rob_id_i;

    alu_ready_o = rdy_i && (alu_cnt_q < FULL_CNT);
    lsb_ready_o = rdy_i && (lsb_cnt_q < FULL_CNT);

`ifdef CDB_BYPASS_EN
    // Live input competes only when nothing older is queued, so order is kept.
    alu_live = rdy_i && alu_valid_i && (alu_cnt_q == '0);
    lsb_live = rdy_i && lsb_valid_i && (lsb_cnt_q == '0);
`else
    alu_live = 1'b0;
    lsb_live = 1'b0;
`endif

    alu_head = (alu_cnt_q != '0) ? alu_mem_q[alu_rptr_q] : alu_in;
    lsb_head = (lsb_cnt_q != '0) ? lsb_mem_q[lsb_rptr_q] : lsb_in;

    alu_cand = rdy_i && ((alu_cnt_q != '0) || alu_live);
    lsb_cand = rdy_i && ((lsb_cnt_q != '0) || lsb_live);

    // Round robin: when both compete, the source not granted last time wins.
    grant_lsb = lsb_cand && (!alu_cand || (last_grant_q == SRC_ALU));
    grant_alu = alu_cand && !grant_lsb;

    alu_pop  = grant_alu && !alu_live;
    lsb_pop  = grant_lsb && !lsb_live;
    alu_push = alu_valid_i && alu_ready_o && !(grant_alu && alu_live);
    lsb_push = lsb_valid_i && lsb_ready_o && !(grant_lsb && lsb_live);

    alu_cnt_d = alu_cnt_q + (PTR_W+1)'(alu_push) - (PTR_W+1)'(alu_pop);
    lsb_cnt_d = lsb_cnt_q + (PTR_W+1)'(lsb_push) - (PTR_W+1)'(lsb_pop);

    last_grant_d = last_grant_q;
    cdb_src_d    = cdb_src_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_d        = cdb_q;
    if (grant_lsb) begin
      cdb_d        = lsb_head;
      cdb_src_d    = SRC_LSB;
      cdb_valid_d  = 1'b1;
      last_grant_d = SRC_LSB;
    end else if (grant_alu) begin
      cdb_d        = alu_head;
      cdb_src_d    = SRC_ALU;
      cdb_valid_d  = 1'b1;
      last_grant_d = SRC_ALU;
    end else if (rdy_i) begin
      // Idle cycle: drop valid, keep the payload stable.
      cdb_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      alu_wptr_q   <= '0;
      alu_rptr_q   <= '0;
      alu_cnt_q    <= '0;
      lsb_wptr_q   <= '0;
      lsb_rptr_q   <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;
      cdb_src_q    <= SRC_ALU;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
    end else begin
      // When rdy_i is low, no push, pop or grant happens, so all _d equal _q.
      alu_wptr_q   <= alu_wptr_q + PTR_W'(alu_push);
      alu_rptr_q   <= alu_rptr_q + PTR_W'(alu_pop);
      alu_cnt_q    <= alu_cnt_d;
      lsb_wptr_q   <= lsb_wptr_q + PTR_W'(lsb_push);
      lsb_rptr_q   <= lsb_rptr_q + PTR_W'(lsb_pop);
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_src_q    <= cdb_src_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
    end
  end

  // NOTE: FIFO storage is not reset. The cleared pointers and counts make any
  // stale contents unreachable.
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem_q[alu_wptr_q] <= alu_in;
    if (lsb_push) lsb_mem_q[lsb_wptr_q] <= lsb_in;
  end

  assign cdb_valid_o       = cdb_valid_q;
  assign cdb_src_o         = cdb_src_q;
  assign cdb_res_o         = cdb_q.res;
  assign cdb_rob_id_o      = cdb_q.rob_id;
  assign cdb_jump_choice_o = cdb_q.jump_choice;
  assign cdb_pc_o          = cdb_q.pc;

endmodule
